// File: rtl/rect_fill_writer.sv
// Rectangle-fill writer for the 640x480, 8-bit frame buffer.
// Software starts a command with a 4-phase start/done handshake. The block then
// writes one pixel per clock to the frame buffer write port. The rectangle is
// clipped to the screen, and row addresses advance by adding H_RES, so no
// multiplier is needed.
// Optional feature: define RECT_OUTLINE_EN to enable outline-only fills.
module rect_fill_writer #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned COLOR_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [9:0]         cmd_x,
  input  logic [9:0]         cmd_y,
  input  logic [9:0]         cmd_w,
  input  logic [9:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               cmd_outline,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  frame_wrAddress,
  output logic [COLOR_W-1:0] frame_input,
  output logic               frame_we
);

  typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

  localparam logic [10:0]       HEnd      = 11'(H_RES);
  localparam logic [10:0]       VEnd      = 11'(V_RES);
  localparam logic [ADDR_W-1:0] RowStride = ADDR_W'(H_RES);

  state_e               state_q, state_d;
  logic [9:0]           x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [10:0]          x_end_q, x_end_d, y_end_q, y_end_d;
  logic [10:0]          col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0]    row_base_q, row_base_d;
  logic                 busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COLOR_W-1:0]   data_q, data_d;

  logic [10:0]          x_sum, y_sum, x_clip, y_clip;
  logic                 empty;
  logic [ADDR_W-1:0]    y_ext, row_base_init;
  logic                 last_col, last_row, pix_we;

  // Clip in 11 bits so that x+w and y+h cannot overflow.
  assign x_sum  = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum  = {1'b0, y_q} + {1'b0, h_q};
  assign x_clip = (x_sum > HEnd) ? HEnd : x_sum;
  assign y_clip = (y_sum > VEnd) ? VEnd : y_sum;
  assign empty  = (w_q == 10'd0) || (h_q == 10'd0) ||
                  ({1'b0, x_q} >= HEnd) || ({1'b0, y_q} >= VEnd);

  // y*640 = (y<<9) + (y<<7); this shift-add assumes H_RES is 640.
  assign y_ext         = ADDR_W'(y_q);
  assign row_base_init = (y_ext << 9) + (y_ext << 7);

  assign last_col = (col_q == x_end_q - 11'd1);
  assign last_row = (row_q == y_end_q - 11'd1);

`ifdef RECT_OUTLINE_EN
  logic outline_q, outline_d;
  logic on_border;
  assign on_border = (row_q == {1'b0, y_q}) || last_row || (col_q == {1'b0, x_q}) || last_col;
  // Interior pixels still take a cycle, but are not written.
  assign pix_we    = !outline_q || on_border;

  // Outline-mode flag, latched together with the rest of the command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) outline_q <= 1'b0;
    else          outline_q <= outline_d;
  end
`else
  logic unused_outline;
  assign unused_outline = cmd_outline;
  assign pix_we         = 1'b1;
`endif

  // Next-state logic for the FSM, the command registers and the registered outputs.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    busy_d     = busy_q;
    done_d     = done_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef RECT_OUTLINE_EN
    outline_d  = outline_q;
`endif
    case (state_q)
      StIdle: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
`ifdef RECT_OUTLINE_EN
          outline_d = cmd_outline;
`endif
          busy_d  = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        x_end_d    = x_clip;
        y_end_d    = y_clip;
        col_d      = {1'b0, x_q};
        row_d      = {1'b0, y_q};
        row_base_d = row_base_init;
        state_d    = empty ? StDone : StFill;
      end
      StFill: begin
        we_d   = pix_we;
        addr_d = row_base_q + ADDR_W'(col_q);
        data_d = color_q;
        if (last_col) begin
          col_d = {1'b0, x_q};
          if (last_row) begin
            state_d = StDone;
          end else begin
            row_d      = row_q + 11'd1;
            row_base_d = row_base_q + RowStride;
          end
        end else begin
          col_d = col_q + 11'd1;
        end
      end
      StDone: begin
        busy_d = 1'b0;
        // done is held for at least one cycle, even if start has already dropped.
        if (!done_q) begin
          done_d = 1'b1;
        end else if (!start) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, command and output registers; reset abandons any fill in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign frame_we        = we_q;
  assign frame_wrAddress = addr_q;
  assign frame_input     = data_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Self-checking bench for rect_fill_writer. A reference model builds the
// expected write sequence directly from the rectangle geometry and clipping rules.
module tb_rect_fill_writer;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 8;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [9:0]         cmd_x, cmd_y, cmd_w, cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic               cmd_outline;
  logic               busy, done, frame_we;
  logic [ADDR_W-1:0]  frame_wrAddress;
  logic [COLOR_W-1:0] frame_input;

  rect_fill_writer #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_outline(cmd_outline),
    .busy(busy), .done(done), .frame_wrAddress(frame_wrAddress),
    .frame_input(frame_input), .frame_we(frame_we)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model output: one entry per fill cycle.
  bit exp_we[$];
  int exp_addr[$];
  // Observations, one entry per cycle after start is sampled.
  logic               obs_we[$], obs_done[$], obs_busy[$];
  logic [ADDR_W-1:0]  obs_addr[$];
  logic [COLOR_W-1:0] obs_data[$];
  // Addresses actually written during the last command.
  int wr_addrs[$];

  task automatic build_model(input int x, input int y, input int w, input int h, input bit outline);
    int xe, ye;
    bit outline_on, edge_pix;
    exp_we.delete();
    exp_addr.delete();
    xe = (x + w < H_RES) ? x + w : H_RES;
    ye = (y + h < V_RES) ? y + h : V_RES;
`ifdef RECT_OUTLINE_EN
    outline_on = outline;
`else
    outline_on = 1'b0;
`endif
    for (int r = y; r < ye; r++) begin
      for (int c = x; c < xe; c++) begin
        edge_pix = (r == y) || (r == ye - 1) || (c == x) || (c == xe - 1);
        exp_addr.push_back(r * H_RES + c);
        exp_we.push_back(!outline_on || edge_pix);
      end
    end
  endtask

  task automatic issue_and_capture(input int x, input int y, input int w, input int h,
                                   input int color, input bit outline, input bit drop_start,
                                   input int ncyc);
    obs_we.delete(); obs_done.delete(); obs_busy.delete();
    obs_addr.delete(); obs_data.delete(); wr_addrs.delete();
    @(negedge clk);
    cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
    cmd_color = 8'(color); cmd_outline = outline;
    start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      obs_we.push_back(frame_we);
      obs_done.push_back(done);
      obs_busy.push_back(busy);
      obs_addr.push_back(frame_wrAddress);
      obs_data.push_back(frame_input);
      if (frame_we === 1'b1) wr_addrs.push_back(int'(frame_wrAddress));
      if (k == 0) begin
        // The command must already be latched; disturb the inputs.
        cmd_x = 10'($urandom); cmd_y = 10'($urandom); cmd_w = 10'($urandom);
        cmd_h = 10'($urandom); cmd_color = 8'($urandom); cmd_outline = 1'($urandom);
        if (drop_start) start = 1'b0;
      end
    end
  endtask

  // One full command: model, stimulus, cycle-by-cycle comparison and handshake release.
  task automatic test_command(input string name, input int x, input int y, input int w,
                              input int h, input int color, input bit outline, input bit drop);
    int n;
    logic e_we, e_done, e_busy;
    build_model(x, y, w, h, outline);
    n = exp_we.size();
    issue_and_capture(x, y, w, h, color, outline, drop, n + 4);
    for (int k = 0; k < n + 3; k++) begin
      e_we   = (k >= 2 && k < 2 + n) ? exp_we[k-2] : 1'b0;
      e_done = (k == 2 + n);
      e_busy = (k < 2 + n);
      n_checks++;
      if ({obs_we[k], obs_done[k], obs_busy[k]} !== {e_we, e_done, e_busy}) begin
        n_fail++;
        $display("FAIL %s ctl cycle %0d: we/done/busy=%b%b%b required %b%b%b", name, k,
                 obs_we[k], obs_done[k], obs_busy[k], e_we, e_done, e_busy);
      end
      if (k >= 2 && k < 2 + n) begin
        n_checks++;
        if (obs_addr[k] !== ADDR_W'(exp_addr[k-2]) ||
            (e_we && obs_data[k] !== COLOR_W'(color))) begin
          n_fail++;
          $display("FAIL %s pixel cycle %0d: addr=%0d data=%h required addr=%0d data=%h",
                   name, k, obs_addr[k], obs_data[k], exp_addr[k-2], color[7:0]);
        end
      end
    end
    if (drop) begin
      n_checks++;
      if (obs_done[n+3] !== 1'b0 || obs_we[n+3] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s release(dropped start): done=%b we=%b required 0 0", name,
                 obs_done[n+3], obs_we[n+3]);
      end
    end else begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({done, busy, frame_we} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s release: done/busy/we=%b%b%b required 000", name, done, busy, frame_we);
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0; cmd_outline = 1'b0;
    #3;
    n_checks++;
    if ({busy, done, frame_we, frame_wrAddress, frame_input} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b done=%b we=%b addr=%0d data=%h required all 0",
               busy, done, frame_we, frame_wrAddress, frame_input);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, frame_we, frame_wrAddress, frame_input} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b we=%b addr=%0d data=%h required all 0",
               busy, done, frame_we, frame_wrAddress, frame_input);
    end
  endtask

  task automatic test_basic;
    int exp_list[6] = '{12810, 12811, 12812, 13450, 13451, 13452};
    test_command("basic", 10, 20, 3, 2, 8'hA5, 1'b0, 1'b0);
    n_checks++;
    if (wr_addrs.size() != 6) begin
      n_fail++;
      $display("FAIL basic_count: writes=%0d required 6", wr_addrs.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (wr_addrs[i] != exp_list[i]) begin
          n_fail++;
          $display("FAIL basic_addr[%0d]: addr=%0d required %0d", i, wr_addrs[i], exp_list[i]);
        end
      end
    end
  endtask

  task automatic test_clip;
    test_command("clip_corner", 638, 479, 5, 4, 8'h3C, 1'b0, 1'b0);
    n_checks++;
    if (wr_addrs.size() != 2 || wr_addrs[0] != 307198 || wr_addrs[1] != 307199) begin
      n_fail++;
      $display("FAIL clip_corner_addrs: count=%0d first=%0d required 2 writes 307198,307199",
               wr_addrs.size(), (wr_addrs.size() > 0) ? wr_addrs[0] : -1);
    end
    test_command("clip_offscreen", 640, 0, 4, 1, 8'h11, 1'b0, 1'b0);
    n_checks++;
    if (wr_addrs.size() != 0 || obs_done[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL clip_offscreen: writes=%0d done@2=%b required 0 writes, done=1",
               wr_addrs.size(), obs_done[2]);
    end
  endtask

  task automatic test_empty;
    test_command("empty_w0", 100, 200, 0, 5, 8'h77, 1'b0, 1'b0);
    n_checks++;
    if (wr_addrs.size() != 0) begin
      n_fail++;
      $display("FAIL empty_w0_writes: writes=%0d required 0", wr_addrs.size());
    end
    test_command("empty_h0", 5, 5, 7, 0, 8'h78, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_fill;
    int seen;
    int budget;
    seen = 0;
    budget = 0;
    @(negedge clk);
    cmd_x = 10'd5; cmd_y = 10'd5; cmd_w = 10'd10; cmd_h = 10'd10; cmd_color = 8'hC3;
    cmd_outline = 1'b0; start = 1'b1;
    while (seen < 3 && budget < 30) begin
      @(negedge clk);
      if (frame_we === 1'b1) seen++;
      budget++;
    end
    n_checks++;
    if (seen < 3) begin
      n_fail++;
      $display("FAIL reset_mid_wait: writes seen=%0d required 3 within budget", seen);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({frame_we, busy, done, frame_wrAddress} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_drop: we=%b busy=%b done=%b addr=%0d required all 0",
               frame_we, busy, done, frame_wrAddress);
    end
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_command("after_reset_1x1", 0, 0, 1, 1, 8'h5A, 1'b0, 1'b0);
    n_checks++;
    if (wr_addrs.size() != 1 || wr_addrs[0] != 0) begin
      n_fail++;
      $display("FAIL after_reset_addr: writes=%0d required single write to 0", wr_addrs.size());
    end
  endtask

  task automatic test_hold_start;
    int extra;
    issue_and_capture(300, 100, 2, 1, 8'h9E, 1'b0, 1'b0, 5);
    n_checks++;
    if (wr_addrs.size() != 2) begin
      n_fail++;
      $display("FAIL hold_first_writes: writes=%0d required 2", wr_addrs.size());
    end
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frame_we === 1'b1 || done !== 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL hold_no_retrigger: bad cycles=%0d required 0", extra);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    test_command("hold_retrigger", 7, 400, 2, 1, 8'h42, 1'b0, 1'b0);
    n_checks++;
    if (wr_addrs.size() != 2) begin
      n_fail++;
      $display("FAIL hold_retrigger_writes: writes=%0d required 2", wr_addrs.size());
    end
  endtask

  task automatic test_outline;
`ifdef RECT_OUTLINE_EN
    bit centre_hit;
    test_command("outline_3x3", 100, 100, 3, 3, 8'hF0, 1'b1, 1'b0);
    centre_hit = 1'b0;
    foreach (wr_addrs[i]) if (wr_addrs[i] == 101 * H_RES + 101) centre_hit = 1'b1;
    n_checks++;
    if (wr_addrs.size() != 8 || centre_hit) begin
      n_fail++;
      $display("FAIL outline_3x3: writes=%0d centre_written=%b required 8 writes, centre 0",
               wr_addrs.size(), centre_hit);
    end
`else
    // Without the feature the outline flag must not change a solid fill.
    test_command("outline_ignored", 100, 100, 3, 3, 8'hF0, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++) begin
      test_command("random", int'($urandom_range(0, 650)), int'($urandom_range(0, 490)),
                   int'($urandom_range(0, 12)), int'($urandom_range(0, 8)),
                   int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_reset_mid_fill();
    test_hold_start();
    test_outline();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
